// File: rtl/rst_sequencer_pkg.sv
// Shared state encodings, default timing parameters and counter sizing helper
// for the staged DRAM/user reset sequencer.
package rst_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_WAIT_CAL = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAIL     = 3'd4
  } state_t;

  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int DEF_SETTLE_CYCLES  = 8;
  localparam int DEF_MAX_RETRY      = 3;

  // Counter only ever reaches (largest cycle parameter - 1), never wraps.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rst_sequencer_sync2.sv
// Two-flop synchronizer for CALIB_DONE crossing from the DRAM clock domain;
// resets to 0 so calibration is never seen as done out of reset.
module rst_sequencer_sync2 (
  input  logic CLK,
  input  logic RST_X,
  input  logic D,
  output logic Q
);

  logic meta;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      meta <= 1'b0;
      Q    <= 1'b0;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: releases the DRAM controller, waits for calibration
// with timeout/retry, then releases user logic. RST_SEQ_CALIB_SYNC_EN adds a
// 2-flop synchronizer on CALIB_DONE.
//
// state    | meaning
// HOLD     | DRAM controller held in reset for HOLD_CYCLES
// WAIT_CAL | DRAM released, waiting for calibration (timeout guarded)
// SETTLE   | calibration seen, must stay high SETTLE_CYCLES
// RUN      | user logic released, INIT_DONE high
// FAIL     | retries exhausted, sticky ERR until SOFT_RST/RST_X
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic       CLK,
  input  logic       RST_X,
  input  logic       CALIB_DONE,
  input  logic       SOFT_RST,
  output logic       DRAMC_RST_X,
  output logic       USER_RST_X,
  output logic       INIT_DONE,
  output logic       ERR,
  output logic [3:0] RETRY_CNT
);

  localparam int CW = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam logic [CW-1:0] HOLD_TC    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_TC = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_TC  = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);

  logic cal;

`ifdef RST_SEQ_CALIB_SYNC_EN
  rst_sequencer_sync2 u_sync2 (
    .CLK   (CLK),
    .RST_X (RST_X),
    .D     (CALIB_DONE),
    .Q     (cal)
  );
`else
  assign cal = CALIB_DONE;
`endif

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          dramc_d, user_d, done_d, err_d;
  logic [3:0]    retry_d;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      DRAMC_RST_X <= 1'b0;
      USER_RST_X  <= 1'b0;
      INIT_DONE   <= 1'b0;
      ERR         <= 1'b0;
      RETRY_CNT   <= 4'd0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      DRAMC_RST_X <= dramc_d;
      USER_RST_X  <= user_d;
      INIT_DONE   <= done_d;
      ERR         <= err_d;
      RETRY_CNT   <= retry_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    dramc_d = DRAMC_RST_X;
    user_d  = USER_RST_X;
    done_d  = INIT_DONE;
    err_d   = ERR;
    retry_d = RETRY_CNT;

    if (SOFT_RST) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      dramc_d = 1'b0;
      user_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      retry_d = 4'd0;
    end else begin
      case (state)
        ST_HOLD: begin
          dramc_d = 1'b0;
          user_d  = 1'b0;
          done_d  = 1'b0;
          if (cnt == HOLD_TC) begin
            state_d = ST_WAIT_CAL;
            cnt_d   = '0;
            dramc_d = 1'b1;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        ST_WAIT_CAL: begin
          // Calibration takes precedence over a timeout landing on the same cycle.
          if (cal) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else if (cnt == TIMEOUT_TC) begin
            cnt_d   = '0;
            dramc_d = 1'b0;
            if (RETRY_CNT < RETRY_MAX) begin
              state_d = ST_HOLD;
              retry_d = RETRY_CNT + 4'd1;
            end else begin
              state_d = ST_FAIL;
              err_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (!cal) begin
            state_d = ST_WAIT_CAL;
            cnt_d   = '0;
          end else if (cnt == SETTLE_TC) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            user_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        ST_RUN: begin
          if (!cal) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            dramc_d = 1'b0;
            user_d  = 1'b0;
            done_d  = 1'b0;
            retry_d = 4'd0;
          end
        end
        ST_FAIL: begin
          dramc_d = 1'b0;
          user_d  = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b1;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          dramc_d = 1'b0;
          user_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed self-checking bench for rst_sequencer; synchronizer latency follows
// RST_SEQ_CALIB_SYNC_EN so the same vectors hold for either build.
module tb_rst_sequencer;

  localparam int HOLD   = 4;
  localparam int TO     = 32;
  localparam int SET    = 3;
  localparam int MAXR   = 2;
`ifdef RST_SEQ_CALIB_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int L = HOLD + TO;

  logic       CLK = 1'b0;
  logic       RST_X = 1'b0;
  logic       CALIB_DONE = 1'b0;
  logic       SOFT_RST = 1'b0;
  logic       DRAMC_RST_X, USER_RST_X, INIT_DONE, ERR;
  logic [3:0] RETRY_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  rst_sequencer #(
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TO),
    .SETTLE_CYCLES  (SET),
    .MAX_RETRY      (MAXR)
  ) dut (
    .CLK         (CLK),
    .RST_X       (RST_X),
    .CALIB_DONE  (CALIB_DONE),
    .SOFT_RST    (SOFT_RST),
    .DRAMC_RST_X (DRAMC_RST_X),
    .USER_RST_X  (USER_RST_X),
    .INIT_DONE   (INIT_DONE),
    .ERR         (ERR),
    .RETRY_CNT   (RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_X = 1'b0; CALIB_DONE = 1'b0; SOFT_RST = 1'b0;
    repeat (3) tick();
    n_checks++; if (DRAMC_RST_X !== 1'b0) begin n_fail++; $display("FAIL reset_dramc: got %b expected 0", DRAMC_RST_X); end
    n_checks++; if (USER_RST_X !== 1'b0) begin n_fail++; $display("FAIL reset_user: got %b expected 0", USER_RST_X); end
    n_checks++; if (INIT_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", INIT_DONE); end
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", ERR); end
    n_checks++; if (RETRY_CNT !== 4'd0) begin n_fail++; $display("FAIL reset_retry: got %0d expected 0", RETRY_CNT); end
  endtask

  task automatic test_nominal();
    logic exp;
    RST_X = 1'b1;
    for (int e = 1; e <= HOLD; e++) begin
      tick();
      exp = (e >= HOLD);
      n_checks++; if (DRAMC_RST_X !== exp) begin n_fail++; $display("FAIL nom_dramc_edge%0d: got %b expected %b", e, DRAMC_RST_X, exp); end
    end
    repeat (10) tick();
    CALIB_DONE = 1'b1;
    for (int k = 1; k <= SYNC + SET + 1; k++) begin
      tick();
      exp = (k >= SYNC + SET + 1);
      n_checks++; if (USER_RST_X !== exp) begin n_fail++; $display("FAIL nom_user_edge%0d: got %b expected %b", k, USER_RST_X, exp); end
      n_checks++; if (INIT_DONE !== exp) begin n_fail++; $display("FAIL nom_done_edge%0d: got %b expected %b", k, INIT_DONE, exp); end
    end
    n_checks++; if (RETRY_CNT !== 4'd0) begin n_fail++; $display("FAIL nom_retry: got %0d expected 0", RETRY_CNT); end
  endtask

  task automatic test_loss_in_run();
    logic exp;
    CALIB_DONE = 1'b0;
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      exp = (k < SYNC + 1);
      n_checks++; if (DRAMC_RST_X !== exp) begin n_fail++; $display("FAIL loss_dramc_edge%0d: got %b expected %b", k, DRAMC_RST_X, exp); end
      n_checks++; if (USER_RST_X !== exp) begin n_fail++; $display("FAIL loss_user_edge%0d: got %b expected %b", k, USER_RST_X, exp); end
      n_checks++; if (INIT_DONE !== exp) begin n_fail++; $display("FAIL loss_done_edge%0d: got %b expected %b", k, INIT_DONE, exp); end
    end
    CALIB_DONE = 1'b1;
    // HOLD re-runs, then cal (already visible) moves straight into SETTLE.
    for (int k = 1; k <= HOLD + 1 + SET; k++) begin
      tick();
      exp = (k >= HOLD + 1 + SET);
      n_checks++; if (USER_RST_X !== exp) begin n_fail++; $display("FAIL loss_rerun_user_edge%0d: got %b expected %b", k, USER_RST_X, exp); end
    end
    n_checks++; if (RETRY_CNT !== 4'd0) begin n_fail++; $display("FAIL loss_retry: got %0d expected 0", RETRY_CNT); end
  endtask

  task automatic test_glitch_settle();
    CALIB_DONE = 1'b0; SOFT_RST = 1'b1;
    tick();
    SOFT_RST = 1'b0;
    n_checks++; if (DRAMC_RST_X !== 1'b0) begin n_fail++; $display("FAIL glitch_soft_dramc: got %b expected 0", DRAMC_RST_X); end
    repeat (HOLD) tick();
    n_checks++; if (DRAMC_RST_X !== 1'b1) begin n_fail++; $display("FAIL glitch_dramc_up: got %b expected 1", DRAMC_RST_X); end
    CALIB_DONE = 1'b1;
    tick(); tick();
    CALIB_DONE = 1'b0;
    // WAIT_CAL is re-entered SYNC+3 edges after the raise; timeout is TO later.
    for (int k = 3; k <= SYNC + 3 + TO; k++) begin
      tick();
      n_checks++; if (USER_RST_X !== 1'b0) begin n_fail++; $display("FAIL glitch_user_edge%0d: got %b expected 0", k, USER_RST_X); end
      if (k == SYNC + 3 + TO - 1) begin
        n_checks++; if (RETRY_CNT !== 4'd0) begin n_fail++; $display("FAIL glitch_retry_pre: got %0d expected 0", RETRY_CNT); end
        n_checks++; if (DRAMC_RST_X !== 1'b1) begin n_fail++; $display("FAIL glitch_dramc_pre: got %b expected 1", DRAMC_RST_X); end
      end
      if (k == SYNC + 3 + TO) begin
        n_checks++; if (RETRY_CNT !== 4'd1) begin n_fail++; $display("FAIL glitch_timeout_retry: got %0d expected 1", RETRY_CNT); end
        n_checks++; if (DRAMC_RST_X !== 1'b0) begin n_fail++; $display("FAIL glitch_timeout_dramc: got %b expected 0", DRAMC_RST_X); end
      end
    end
  endtask

  task automatic test_retries_exhausted();
    CALIB_DONE = 1'b0; SOFT_RST = 1'b1;
    tick();
    SOFT_RST = 1'b0;
    n_checks++; if (RETRY_CNT !== 4'd0) begin n_fail++; $display("FAIL retr_soft_retry: got %0d expected 0", RETRY_CNT); end
    for (int e = 1; e <= 3 * L + 10; e++) begin
      tick();
      if (e == L - 1 || e == 2 * L - 1 || e == 3 * L - 1) begin
        n_checks++; if (DRAMC_RST_X !== 1'b1) begin n_fail++; $display("FAIL retr_dramc_edge%0d: got %b expected 1", e, DRAMC_RST_X); end
        n_checks++; if (RETRY_CNT !== 4'(e / L)) begin n_fail++; $display("FAIL retr_cnt_edge%0d: got %0d expected %0d", e, RETRY_CNT, e / L); end
        n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL retr_err_edge%0d: got %b expected 0", e, ERR); end
      end
      if (e == L || e == 2 * L) begin
        n_checks++; if (DRAMC_RST_X !== 1'b0) begin n_fail++; $display("FAIL retr_dramc_edge%0d: got %b expected 0", e, DRAMC_RST_X); end
        n_checks++; if (RETRY_CNT !== 4'(e / L)) begin n_fail++; $display("FAIL retr_cnt_edge%0d: got %0d expected %0d", e, RETRY_CNT, e / L); end
      end
      if (e == L + HOLD || e == 2 * L + HOLD) begin
        n_checks++; if (DRAMC_RST_X !== 1'b1) begin n_fail++; $display("FAIL retr_rehold_edge%0d: got %b expected 1", e, DRAMC_RST_X); end
      end
      if (e == 3 * L || e == 3 * L + 10) begin
        n_checks++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL retr_fail_err_edge%0d: got %b expected 1", e, ERR); end
        n_checks++; if (DRAMC_RST_X !== 1'b0) begin n_fail++; $display("FAIL retr_fail_dramc_edge%0d: got %b expected 0", e, DRAMC_RST_X); end
        n_checks++; if (RETRY_CNT !== 4'(MAXR)) begin n_fail++; $display("FAIL retr_fail_cnt_edge%0d: got %0d expected %0d", e, RETRY_CNT, MAXR); end
        n_checks++; if (USER_RST_X !== 1'b0) begin n_fail++; $display("FAIL retr_fail_user_edge%0d: got %b expected 0", e, USER_RST_X); end
      end
    end
  endtask

  task automatic test_recovery();
    logic exp;
    CALIB_DONE = 1'b1; SOFT_RST = 1'b1;
    tick();
    SOFT_RST = 1'b0;
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL rec_err: got %b expected 0", ERR); end
    n_checks++; if (RETRY_CNT !== 4'd0) begin n_fail++; $display("FAIL rec_retry: got %0d expected 0", RETRY_CNT); end
    for (int k = 1; k <= HOLD + 1 + SET; k++) begin
      tick();
      exp = (k >= HOLD);
      n_checks++; if (DRAMC_RST_X !== exp) begin n_fail++; $display("FAIL rec_dramc_edge%0d: got %b expected %b", k, DRAMC_RST_X, exp); end
      exp = (k >= HOLD + 1 + SET);
      n_checks++; if (INIT_DONE !== exp) begin n_fail++; $display("FAIL rec_done_edge%0d: got %b expected %b", k, INIT_DONE, exp); end
    end
    n_checks++; if (USER_RST_X !== 1'b1) begin n_fail++; $display("FAIL rec_user: got %b expected 1", USER_RST_X); end
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL rec_err_final: got %b expected 0", ERR); end
  endtask

  task automatic test_async_reset();
    CALIB_DONE = 1'b0; SOFT_RST = 1'b1;
    tick();
    SOFT_RST = 1'b0;
    repeat (L + HOLD + 2) tick();
    n_checks++; if (RETRY_CNT !== 4'd1) begin n_fail++; $display("FAIL async_pre_retry: got %0d expected 1", RETRY_CNT); end
    n_checks++; if (DRAMC_RST_X !== 1'b1) begin n_fail++; $display("FAIL async_pre_dramc: got %b expected 1", DRAMC_RST_X); end
    #2;
    RST_X = 1'b0;
    #1;
    n_checks++; if (DRAMC_RST_X !== 1'b0) begin n_fail++; $display("FAIL async_dramc: got %b expected 0", DRAMC_RST_X); end
    n_checks++; if (RETRY_CNT !== 4'd0) begin n_fail++; $display("FAIL async_retry: got %0d expected 0", RETRY_CNT); end
    n_checks++; if ({USER_RST_X, INIT_DONE, ERR} !== 3'b000) begin n_fail++; $display("FAIL async_others: got %b expected 000", {USER_RST_X, INIT_DONE, ERR}); end
    tick();
    RST_X = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_loss_in_run();
    test_glitch_settle();
    test_retries_exhausted();
    test_recovery();
    test_async_reset();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
